d_e_decode_reg: RTL
===================

# d_e_decode_reg

Decode-and-register block between pipeline stage D and stage E of the five-stage MIPS core. Decodes the D-stage instruction into the E-stage ALU controls (alu_op, extended immediate), write-back controls and hazard timing (Tnew). Registers them together with the forwarded operands into the D/E pipeline register. Supports hazard-driven bubble insertion, flush and asynchronous reset. It is the producer of every control the E-stage ALU consumes.

## Interface
Parameters:
- none; all widths fixed by the 32-bit MIPS datapath.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears the register immediately, independent of clk.
- instr_D  in  32  D-stage instruction word.
- pc_D  in  32  D-stage PC.
- rs_D  in  32  rs operand, already forwarded in D.
- rt_D  in  32  rt operand, already forwarded in D.
- stall  in  1  from hazard unit; load a bubble into E this cycle.
- flush  in  1  load a bubble into E this cycle (same effect as stall).
- valid_E  out  1  E slot holds a real instruction.
- alu_op_E  out  4  0 add, 1 sub, 2 or-imm, 3 mem address, 4 lui, 5 sll.
- ext_E  out  32  extended immediate or shamt.
- rs_E, rt_E  out  32  registered operands.
- pc_E, instr_E  out  32  registered PC and instruction.
- wa_E  out  5  destination register; 0 means no write.
- reg_write_E  out  1  register write-back enable.
- mem_write_E  out  1  store.
- mem_to_reg_E  out  1  write-back data source is the load result.
- tnew_E  out  2  cycles until the result is available, counted from E.
- illegal_E  out  1  the registered instruction was undecodable.

## Operation
- Decode key: opcode = instr[31:26]; funct = instr[5:0] for opcode 0.
- add (0/100000): alu_op 0, wa = rd, tnew 1.
- sub (0/100010): alu_op 1, wa = rd, tnew 1.
- sll (0/000000): alu_op 5, ext = zero-extended shamt instr[10:6], wa = rd, tnew 1.
- jr (0/001000): alu_op 0, no write, tnew 0.
- ori (001101): alu_op 2, ext = zero-extended imm16, wa = rt, tnew 1.
- lui (001111): alu_op 4, ext = zero-extended imm16 (the ALU shifts by 16), wa = rt, tnew 1.
- lw (100011): alu_op 3, ext = sign-extended imm16, wa = rt, mem_to_reg 1, tnew 2.
- sw (101011): alu_op 3, ext = sign-extended imm16, mem_write 1, no write, tnew 0.
- beq (000100): resolved in D; alu_op 0, ext = sign-extended imm16, no write, tnew 0.
- jal (000011): alu_op 0, wa = 31, reg_write 1, tnew 0 (link value pc_D+8 is produced in E).
- Instruction word 0x00000000 is nop: all controls 0, valid 1, illegal 0.
- Write to $0: if the decoded wa == 0, force reg_write = 0 and tnew = 0.
- Unknown opcode or funct: decode as nop, illegal = 1, valid 1.
- Bubble value (on reset, stall or flush): every output 0, including valid_E and instr_E.

## Timing
- Combinational decode of instr_D.
- Results register on the rising clk edge; E outputs are valid one cycle after D presents the instruction. Latency is 1 cycle.
- stall or flush high at an edge: E receives the bubble. The D inputs are ignored; the hazard unit holds D upstream.
- stall and flush high together: bubble (same as either alone).
- Neither asserted: E captures the decoded D instruction.
- reset asserted: all outputs go to 0 immediately and stay 0 while reset is high.
- reset deasserted: the first capture happens at the next rising edge.
- Reset asserted mid-stream discards the in-flight E instruction.
- No combinational path from any input to any output.

## Structure
- Shared package mips_pkg holds:
  - opcode and funct constants;
  - alu_op encodings 0–5, identical to the E-stage ALU's case values;
  - TNEW_0/1/2 constants;
  - the bubble constant.
- Sub-module instr_decode is purely combinational: instr in, control bundle out.
- The top level is the instr_decode instance plus the D/E register with bubble mux.

## Test plan
- ori $1,$2,0xFFFF (0x3441FFFF), no stall → next cycle: alu_op_E 2, ext_E 0x0000FFFF, wa_E 1, reg_write_E 1, tnew_E 1, valid_E 1.
- lw $3,-4($4) (0x8C83FFFC) → alu_op_E 3, ext_E 0xFFFFFFFC, mem_to_reg_E 1, tnew_E 2. Then sw $3,8($4) (0xAC830008) → ext_E 0x00000008, mem_write_E 1, reg_write_E 0.
- sll $5,$6,7 (0x000629C0) → alu_op_E 5, ext_E 7, wa_E 5.
  - add $0,$1,$2 → reg_write_E 0, tnew_E 0.
  - jal → wa_E 31, reg_write_E 1.
- Back-to-back add, sub, with stall high on the second edge → E shows add, then bubble (all 0, valid_E 0). Flush plus stall together → bubble.
- reset pulsed asynchronously mid-cycle while E holds lw → all outputs 0 before the next edge. Opcode 0x3F → illegal_E 1, reg_write_E 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared decode constants, control bundle and D/E register layout for the MIPS core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    // These values are the E-stage ALU's case labels; keep them in lockstep.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_ORI = 4'd2;
    localparam logic [3:0] ALU_MEM = 4'd3;
    localparam logic [3:0] ALU_LUI = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_op;
        logic [31:0] ext;
        logic [4:0]  wa;
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic [1:0]  tnew;
        logic        illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
    } e_reg_t;

    localparam e_reg_t BUBBLE = '0;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of a D-stage instruction into the E-stage control bundle.
module instr_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        bad;

    assign op   = instr[31:26];
    assign fn   = instr[5:0];
    assign rt   = instr[20:16];
    assign rd   = instr[15:11];
    assign sext = {{16{instr[15]}}, instr[15:0]};
    assign zext = {16'h0000, instr[15:0]};

    always_comb begin
        ctrl = '0;
        ctrl.valid = 1'b1;
        bad = 1'b0;
        case (op)
            OP_RTYPE: case (fn)
                FN_ADD: {ctrl.alu_op, ctrl.wa, ctrl.reg_write, ctrl.tnew} = {ALU_ADD, rd, 1'b1, TNEW_1};
                FN_SUB: {ctrl.alu_op, ctrl.wa, ctrl.reg_write, ctrl.tnew} = {ALU_SUB, rd, 1'b1, TNEW_1};
                FN_SLL: begin
                    {ctrl.alu_op, ctrl.wa, ctrl.reg_write, ctrl.tnew} = {ALU_SLL, rd, 1'b1, TNEW_1};
                    ctrl.ext = {27'd0, instr[10:6]};
                end
                FN_JR:  ctrl.alu_op = ALU_ADD;
                default: bad = 1'b1;
            endcase
            OP_ORI: begin
                {ctrl.alu_op, ctrl.wa, ctrl.reg_write, ctrl.tnew} = {ALU_ORI, rt, 1'b1, TNEW_1};
                ctrl.ext = zext;
            end
            OP_LUI: begin
                {ctrl.alu_op, ctrl.wa, ctrl.reg_write, ctrl.tnew} = {ALU_LUI, rt, 1'b1, TNEW_1};
                ctrl.ext = zext;
            end
            OP_LW: begin
                {ctrl.alu_op, ctrl.wa, ctrl.reg_write, ctrl.tnew} = {ALU_MEM, rt, 1'b1, TNEW_2};
                ctrl.ext = sext;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_op = ALU_MEM;
                ctrl.ext = sext;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: {ctrl.alu_op, ctrl.ext} = {ALU_ADD, sext};
            OP_JAL: {ctrl.alu_op, ctrl.wa, ctrl.reg_write, ctrl.tnew} = {ALU_ADD, 5'd31, 1'b1, TNEW_0};
            default: bad = 1'b1;
        endcase
        // The all-zero word would otherwise decode as sll $0 with a nonzero alu_op.
        if (bad || instr == '0) begin
            ctrl = '0;
            ctrl.valid = 1'b1;
            ctrl.illegal = bad;
        end
        if (ctrl.wa == 5'd0) begin
            ctrl.reg_write = 1'b0;
            ctrl.tnew = TNEW_0;
        end
    end

endmodule

// File: rtl/d_e_decode_reg.sv
// d_e_decode_reg: decodes the D-stage instruction and holds it, with its operands,
// in the D/E pipeline register; stall or flush loads a bubble.
module d_e_decode_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    input  logic [31:0] pc_D,
    input  logic [31:0] rs_D,
    input  logic [31:0] rt_D,
    input  logic        stall,
    input  logic        flush,
    output logic        valid_E,
    output logic [3:0]  alu_op_E,
    output logic [31:0] ext_E,
    output logic [31:0] rs_E,
    output logic [31:0] rt_E,
    output logic [31:0] pc_E,
    output logic [31:0] instr_E,
    output logic [4:0]  wa_E,
    output logic        reg_write_E,
    output logic        mem_write_E,
    output logic        mem_to_reg_E,
    output logic [1:0]  tnew_E,
    output logic        illegal_E
);

    ctrl_t  ctrl_D;
    e_reg_t e;

    instr_decode u_dec (
        .instr(instr_D),
        .ctrl (ctrl_D)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            e <= BUBBLE;
        else
            e <= (stall || flush) ? BUBBLE : {ctrl_D, pc_D, instr_D, rs_D, rt_D};
    end

    assign valid_E      = e.ctrl.valid;
    assign alu_op_E     = e.ctrl.alu_op;
    assign ext_E        = e.ctrl.ext;
    assign wa_E         = e.ctrl.wa;
    assign reg_write_E  = e.ctrl.reg_write;
    assign mem_write_E  = e.ctrl.mem_write;
    assign mem_to_reg_E = e.ctrl.mem_to_reg;
    assign tnew_E       = e.ctrl.tnew;
    assign illegal_E    = e.ctrl.illegal;
    assign rs_E         = e.rs;
    assign rt_E         = e.rt;
    assign pc_E         = e.pc;
    assign instr_E      = e.instr;

endmodule
